// File: rtl/fp_div_special_stage.sv
// Registered special-case stage for an IEEE-754 divider: classifies both
// operands, resolves NaN/inf/zero quotients and tracks exception stickies.
module fp_div_special_stage #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_a,
  output logic [EXP_W+MAN_W:0]   out_b,
  output logic [2:0]             a_class,
  output logic [2:0]             b_class,
  output logic                   res_sign,
  output logic                   special,
  output logic [EXP_W+MAN_W:0]   special_result,
  output logic                   flag_invalid,
  output logic                   flag_divzero,
  output logic                   sticky_invalid,
  output logic                   sticky_divzero,
  input  logic                   clr_sticky,
  output logic [CNT_W-1:0]       special_count
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_DENORM = 3'd1;
  localparam logic [2:0] CLS_NORM   = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_QNAN   = 3'd4;
  localparam logic [2:0] CLS_SNAN   = 3'd5;

  localparam logic [W-1:0] CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand class from exponent/mantissa fields; denormals stay finite nonzero.
  function automatic logic [2:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [2:0]       c;
    e = x[MAN_W +: EXP_W];
    m = x[MAN_W-1:0];
    c = CLS_NORM;
    if (e == '0) begin
      c = (m == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (e == '1) begin
      if (m == '0)          c = CLS_INF;
      else if (m[MAN_W-1])  c = CLS_QNAN;
      else                  c = CLS_SNAN;
    end
    return c;
  endfunction

  logic           accept;
  logic [2:0]     nxt_a_class;
  logic [2:0]     nxt_b_class;
  logic           nxt_sign;
  logic           nxt_special;
  logic [W-1:0]   nxt_result;
  logic           nxt_invalid;
  logic           nxt_divzero;
  logic           a_nan;
  logic           b_nan;
  logic           any_snan;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign nxt_a_class = classify(a);
  assign nxt_b_class = classify(b);
  assign nxt_sign    = a[W-1] ^ b[W-1];

  assign a_nan    = (nxt_a_class == CLS_QNAN) || (nxt_a_class == CLS_SNAN);
  assign b_nan    = (nxt_b_class == CLS_QNAN) || (nxt_b_class == CLS_SNAN);
  assign any_snan = (nxt_a_class == CLS_SNAN) || (nxt_b_class == CLS_SNAN);

  // Priority resolution: NaN, invalid forms, inf dividend, divide-by-zero, zero quotient.
  always_comb begin
    nxt_special = 1'b0;
    nxt_result  = '0;
    nxt_invalid = 1'b0;
    nxt_divzero = 1'b0;
    if (a_nan || b_nan) begin
      nxt_special = 1'b1;
      nxt_result  = CANON_QNAN;
      nxt_invalid = any_snan;
    end else if (((nxt_a_class == CLS_ZERO) && (nxt_b_class == CLS_ZERO)) ||
                 ((nxt_a_class == CLS_INF)  && (nxt_b_class == CLS_INF))) begin
      nxt_special = 1'b1;
      nxt_result  = CANON_QNAN;
      nxt_invalid = 1'b1;
    end else if (nxt_a_class == CLS_INF) begin
      nxt_special = 1'b1;
      nxt_result  = {nxt_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (nxt_b_class == CLS_ZERO) begin
      nxt_special = 1'b1;
      nxt_result  = {nxt_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      nxt_divzero = 1'b1;
    end else if ((nxt_a_class == CLS_ZERO) || (nxt_b_class == CLS_INF)) begin
      nxt_special = 1'b1;
      nxt_result  = {nxt_sign, {(W-1){1'b0}}};
    end
  end

  // Result register: loads on accept, drains on handshake, holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_a          <= '0;
      out_b          <= '0;
      a_class        <= CLS_ZERO;
      b_class        <= CLS_ZERO;
      res_sign       <= 1'b0;
      special        <= 1'b0;
      special_result <= '0;
      flag_invalid   <= 1'b0;
      flag_divzero   <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_a          <= a;
      out_b          <= b;
      a_class        <= nxt_a_class;
      b_class        <= nxt_b_class;
      res_sign       <= nxt_sign;
      special        <= nxt_special;
      special_result <= nxt_result;
      flag_invalid   <= nxt_invalid;
      flag_divzero   <= nxt_divzero;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

  // Stickies: a same-cycle accepted flag overrides the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_invalid <= 1'b0;
      sticky_divzero <= 1'b0;
    end else begin
      sticky_invalid <= (sticky_invalid && !clr_sticky) || (accept && nxt_invalid);
      sticky_divzero <= (sticky_divzero && !clr_sticky) || (accept && nxt_divzero);
    end
  end

  // Saturating count of accepted special results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      special_count <= '0;
    end else if (accept && nxt_special && (special_count != '1)) begin
      special_count <= special_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_div_special_stage.sv
// Randomised bench for fp_div_special_stage against a field-level reference
// model, plus directed literal checks on single and half precision instances.
module tb_fp_div_special_stage;

  localparam int unsigned CNT_W = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, clr_sticky;
  logic [31:0] a, b;
  logic        in_ready, out_valid, res_sign, special, flag_invalid, flag_divzero;
  logic        sticky_invalid, sticky_divzero;
  logic [31:0] out_a, out_b, special_result;
  logic [2:0]  a_class, b_class;
  logic [CNT_W-1:0] special_count;

  fp_div_special_stage #(.EXP_W(8), .MAN_W(23), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .a_class(a_class), .b_class(b_class),
    .res_sign(res_sign), .special(special), .special_result(special_result),
    .flag_invalid(flag_invalid), .flag_divzero(flag_divzero),
    .sticky_invalid(sticky_invalid), .sticky_divzero(sticky_divzero),
    .clr_sticky(clr_sticky), .special_count(special_count)
  );

  logic        h_in_valid, h_out_ready, h_clr;
  logic [15:0] h_a, h_b;
  logic        h_in_ready, h_out_valid, h_res_sign, h_special, h_flag_invalid, h_flag_divzero;
  logic        h_sticky_invalid, h_sticky_divzero;
  logic [15:0] h_out_a, h_out_b, h_special_result;
  logic [2:0]  h_a_class, h_b_class;
  logic [15:0] h_special_count;

  fp_div_special_stage #(.EXP_W(5), .MAN_W(10), .CNT_W(16)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_a(h_out_a), .out_b(h_out_b), .a_class(h_a_class), .b_class(h_b_class),
    .res_sign(h_res_sign), .special(h_special), .special_result(h_special_result),
    .flag_invalid(h_flag_invalid), .flag_divzero(h_flag_divzero),
    .sticky_invalid(h_sticky_invalid), .sticky_divzero(h_sticky_divzero),
    .clr_sticky(h_clr), .special_count(h_special_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic        sign;
    logic        special;
    logic [31:0] res;
    logic        inv;
    logic        dz;
  } ref_t;

  // Class from decoded integer fields of a single-precision value.
  function automatic logic [2:0] ref_class(input logic [31:0] x);
    int e;
    int m;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 0)   return (m == 0) ? 3'd0 : 3'd1;
    if (e == 255) begin
      if (m == 0)        return 3'd3;
      if (m >= 4194304)  return 3'd4;
      return 3'd5;
    end
    return 3'd2;
  endfunction

  function automatic ref_t ref_div(input logic [31:0] x, input logic [31:0] y);
    ref_t r;
    logic nan_in, snan_in;
    r = '0;
    r.ca   = ref_class(x);
    r.cb   = ref_class(y);
    r.sign = x[31] ^ y[31];
    nan_in  = (r.ca >= 3'd4) || (r.cb >= 3'd4);
    snan_in = (r.ca == 3'd5) || (r.cb == 3'd5);
    r.special = 1'b1;
    if (nan_in) begin
      r.res = 32'h7FC00000; r.inv = snan_in;
    end else if ((r.ca == 3'd0 && r.cb == 3'd0) || (r.ca == 3'd3 && r.cb == 3'd3)) begin
      r.res = 32'h7FC00000; r.inv = 1'b1;
    end else if (r.ca == 3'd3) begin
      r.res = r.sign ? 32'hFF800000 : 32'h7F800000;
    end else if (r.cb == 3'd0) begin
      r.res = r.sign ? 32'hFF800000 : 32'h7F800000; r.dz = 1'b1;
    end else if (r.ca == 3'd0 || r.cb == 3'd3) begin
      r.res = r.sign ? 32'h80000000 : 32'h00000000;
    end else begin
      r.special = 1'b0;
    end
    return r;
  endfunction

  // Reference stage state
  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  ref_t        m_r = '0;
  logic        m_sinv = 1'b0, m_sdz = 1'b0;
  int          m_cnt = 0;
  logic        cmp_en = 1'b0;

  always @(posedge clk) begin
    ref_t r;
    logic acc;
    r   = ref_div(a, b);
    acc = in_valid && (!m_valid || out_ready);
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sinv  <= 1'b0;
      m_sdz   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      if (acc) begin
        m_valid <= 1'b1;
        m_a     <= a;
        m_b     <= b;
        m_r     <= r;
        if (r.special && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      m_sinv <= (m_sinv && !clr_sticky) || (acc && r.inv);
      m_sdz  <= (m_sdz  && !clr_sticky) || (acc && r.dz);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("sticky_invalid", 64'(sticky_invalid), 64'(m_sinv));
      check("sticky_divzero", 64'(sticky_divzero), 64'(m_sdz));
      check("special_count", 64'(special_count), 64'(m_cnt));
      if (m_valid) begin
        check("out_a", 64'(out_a), 64'(m_a));
        check("out_b", 64'(out_b), 64'(m_b));
        check("a_class", 64'(a_class), 64'(m_r.ca));
        check("b_class", 64'(b_class), 64'(m_r.cb));
        check("res_sign", 64'(res_sign), 64'(m_r.sign));
        check("special", 64'(special), 64'(m_r.special));
        check("special_result", 64'(special_result), 64'(m_r.res));
        check("flag_invalid", 64'(flag_invalid), 64'(m_r.inv));
        check("flag_divzero", 64'(flag_divzero), 64'(m_r.dz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    a = x;
    b = y;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom);
    case ($urandom % 4)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom % 4)
      0:       m = 23'h0;
      1:       m = 23'h400000 | 23'($urandom);
      2:       m = 23'($urandom) & 23'h3FFFFF;
      default: m = 23'($urandom);
    endcase
    return {s, e, m};
  endfunction

  initial begin
    ref_t p;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0; a = '0; b = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_clr = 1'b0; h_a = '0; h_b = '0;

    // Model pins
    p = ref_div(32'h7F800000, 32'hFF800000);
    check("model_inf_inf", {p.res, 31'b0, p.inv}, {32'h7FC00000, 31'b0, 1'b1});
    p = ref_div(32'h80000000, 32'h7F800000);
    check("model_zero_inf", {p.res, 31'b0, p.special}, {32'h80000000, 31'b0, 1'b1});
    p = ref_div(32'hBF800000, 32'h00000001);
    check("model_norm_denorm", {p.ca, p.cb, p.special, p.dz}, {3'd2, 3'd1, 1'b0, 1'b0});

    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_special_count", 64'(special_count), 64'd0);
    check("rst_result", 64'(special_result), 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    send(32'h3F800000, 32'h00000000);
    check("d33_out_valid", 64'(out_valid), 64'd1);
    check("d33_special", 64'(special), 64'd1);
    check("d33_result", 64'(special_result), 64'h7F800000);
    check("d33_divzero", 64'(flag_divzero), 64'd1);
    check("d33_b_class", 64'(b_class), 64'd0);

    send(32'h00000000, 32'h80000000);
    check("d34_result", 64'(special_result), 64'h7FC00000);
    check("d34_invalid", 64'(flag_invalid), 64'd1);
    check("d34_sign", 64'(res_sign), 64'd1);
    send(32'h00000001, 32'h3F800000);
    check("d34_a_class", 64'(a_class), 64'd1);
    check("d34_special", 64'(special), 64'd0);

    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    send(32'h7F800001, 32'h40000000);
    check("d35_a_class", 64'(a_class), 64'd5);
    check("d35_result", 64'(special_result), 64'h7FC00000);
    check("d35_invalid", 64'(flag_invalid), 64'd1);
    tick();
    tick();
    check("d35_sticky_held", 64'(sticky_invalid), 64'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("d35_sticky_clr", 64'(sticky_invalid), 64'd0);

    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h00000000; b = 32'h3F800000;
    tick();
    a = 32'h7F800000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d36_in_ready", 64'(in_ready), 64'd0);
      check("d36_hold", {32'(out_b), 31'b0, special}, {32'h3F800000, 31'b0, 1'b1});
      check("d36_count", 64'(special_count), 64'd4);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("d36_reload", 64'(special_result), 64'h7F800000);
    check("d37_pre_count", 64'(special_count), 64'd5);
    check("d37_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    check("d37_valid", 64'(out_valid), 64'd0);
    check("d37_count", 64'(special_count), 64'd0);
    check("d37_stickies", {sticky_invalid, sticky_divzero}, 2'b00);
    rst_n = 1'b1;

    h_in_valid = 1'b1; h_a = 16'h7C00; h_b = 16'h7C00;
    tick();
    check("d38_result", 64'(h_special_result), 64'h7E00);
    check("d38_invalid", 64'(h_flag_invalid), 64'd1);
    h_a = 16'hBC00; h_b = 16'h0000;
    tick();
    h_in_valid = 1'b0;
    check("h_divzero_result", 64'(h_special_result), 64'hFC00);
    check("h_divzero_flag", 64'(h_flag_divzero), 64'd1);

    for (int i = 0; i < 4000; i++) begin
      rst_n      = ($urandom % 500) != 0;
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 3) != 0;
      clr_sticky = ($urandom % 16) == 0;
      a = rand_op();
      b = rand_op();
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_special_stage.md
FP_DIV_SPECIAL_STAGE -- requirements
Module: fp_div_special_stage

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width; W = 1+EXP_W+MAN_W throughout.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa width.
REQ-003 SHALL have parameter CNT_W, default 16, special-event counter width.
REQ-004 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  operand pair offered.
REQ-007 SHALL have port in_ready  out  1  stage accepts operands this cycle.
REQ-008 SHALL have ports a, b  in  W each  dividend and divisor, IEEE-754 layout {sign, exp, mant}.
REQ-009 SHALL have port out_valid  out  1  registered result held.
REQ-010 SHALL have port out_ready  in  1  downstream accepts result.
REQ-011 SHALL have ports out_a, out_b  out  W each  registered copies of the accepted operands.
REQ-012 SHALL have ports a_class, b_class  out  3 each  0 zero, 1 denormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN.
REQ-013 SHALL have port res_sign  out  1  a.sign XOR b.sign.
REQ-014 SHALL have port special  out  1  result fully determined here; special_result valid.
REQ-015 SHALL have port special_result  out  W  special-case quotient, 0 when special=0.
REQ-016 SHALL have ports flag_invalid, flag_divzero  out  1 each  per-result exception flags.
REQ-017 SHALL have ports sticky_invalid, sticky_divzero  out  1 each  accumulated flags.
REQ-018 SHALL have port clr_sticky  in  1  clears sticky flags.
REQ-019 SHALL have port special_count  out  CNT_W  saturating count of accepted special=1 results.

Function
REQ-020 SHALL classify each operand from its own exponent and mantissa: exp=0,mant=0 zero; exp=0,mant!=0 denormal; exp all-ones,mant=0 inf; exp all-ones,mant MSB=1 qNaN; exp all-ones,mant MSB=0,mant!=0 sNaN; else normal.
REQ-021 SHALL treat denormals as finite nonzero; a denormal divisor is never a divide-by-zero.
REQ-022 SHALL resolve special cases in priority order: (1) any NaN -> canonical qNaN, invalid=1 iff any sNaN; (2) 0/0 or inf/inf -> canonical qNaN, invalid=1; (3) a inf -> inf with res_sign; (4) b zero -> inf with res_sign, divzero=1; (5) a zero or b inf -> zero with res_sign; else special=0.
REQ-023 SHALL form canonical qNaN as sign 0, exp all-ones, mant MSB 1, remaining mant bits 0.
REQ-024 SHALL be a one-entry registered stage: in_ready = !out_valid || out_ready; transfer when in_valid && in_ready; latency exactly 1 cycle from accept to out_valid=1.
REQ-025 SHALL hold all outputs except stickies and counter stable while out_valid=1 && out_ready=0.
REQ-026 SHALL clear out_valid after out_valid && out_ready with no new accept in the same cycle; SHALL reload same cycle when both occur (full throughput).
REQ-027 SHALL OR flag_invalid/flag_divzero of each accepted result into the stickies on the accept edge.
REQ-028 SHALL clear stickies on clr_sticky, except a flag set by a same-cycle accept, which wins (ends set).
REQ-029 SHALL increment special_count on each accept with special=1, saturating at all-ones, never wrapping.
REQ-030 SHALL ignore a and b when in_valid=0 or in_ready=0.

Reset
REQ-031 SHALL, on rising edge with rst_n=0, clear out_valid, out_a, out_b, classes, res_sign, special, special_result, flags, stickies, special_count to 0.
REQ-032 SHALL drop any held result on reset mid-operation; in_ready=1 on the first cycle after reset release.

Verification (W=32 unless stated)
REQ-033 SHALL verify a=0x3F800000, b=0x00000000 -> next cycle out_valid=1, special=1, special_result=0x7F800000, flag_divzero=1, b_class=0.
REQ-034 SHALL verify a=0x00000000, b=0x80000000 -> special_result=0x7FC00000, flag_invalid=1, res_sign=1; a=0x00000001, b=0x3F800000 -> a_class=1, special=0.
REQ-035 SHALL verify a=0x7F800001, b=0x40000000 -> a_class=5, special_result=0x7FC00000, flag_invalid=1, sticky_invalid=1 until clr_sticky.
REQ-036 SHALL verify out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, special_count unchanged until release.
REQ-037 SHALL verify rst_n=0 while out_valid=1 and special_count=5 -> next cycle out_valid=0, special_count=0, stickies=0.
REQ-038 SHALL verify EXP_W=5, MAN_W=10, a=0x7C00, b=0x7C00 -> special_result=0x7E00, flag_invalid=1.
